ahblite_busmatrix_inputstage: RTL and testbench

// - Per-master slave-side stage of the AHB-Lite bus matrix, upstream of every output stage (DTCM, ITCM, AHB2APB).
// - Captures a master's address phase whenever the target output stage has not granted this port.
// - Drives TRANS_HOLD plus the held or live address-phase signals towards the decoder and output stages.
// - Stalls the master with HREADYOUT=0 until the held transfer is accepted, then forwards the data-phase response.

---
 rtl/ahblite_busmatrix_pkg.sv | 26 ++
 rtl/ahblite_busmatrix_inputstage.sv | 104 ++++++++++
 tb/tb_ahblite_busmatrix_inputstage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_busmatrix_pkg.sv
// Shared AHB-Lite bus matrix definitions: transfer codes,
// response codes, port IDs and the captured control bundle.
package ahblite_busmatrix_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] PORT_SYS = 2'b01;
  localparam logic [1:0] PORT_DMA = 2'b10;
  localparam logic [1:0] PORT_ACC = 2'b11;

  typedef struct packed {
    logic       hsel;
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
  } ctrl_t;

endpackage

// File: rtl/ahblite_busmatrix_inputstage.sv
// Per-master input stage: holds an address phase until the
// target output stage grants it, and stalls the master meanwhile.
module ahblite_busmatrix_inputstage
  import ahblite_busmatrix_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HREADY,
  input  logic                  ACTIVE_DEC,
  input  logic                  HREADY_DEC,
  input  logic                  HREADYOUT_DEC,
  input  logic                  HRESP_DEC,
  output logic                  TRANS_HOLD,
  output logic                  HSEL_O,
  output logic [ADDR_WIDTH-1:0] HADDR_O,
  output logic [1:0]            HTRANS_O,
  output logic                  HWRITE_O,
  output logic [2:0]            HSIZE_O,
  output logic [2:0]            HBURST_O,
  output logic [3:0]            HPROT_O,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  logic                  hold_q, hold_d;
  logic                  data_phase_q, data_phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  ctrl_t                 ctrl_q, ctrl_d;
  ctrl_t                 ctrl_live, ctrl_o;

  logic trans_req;
  logic accept;
  logic capture;

  assign ctrl_live = '{hsel: HSEL, htrans: HTRANS, hwrite: HWRITE,
                       hsize: HSIZE, hburst: HBURST, hprot: HPROT};

  assign trans_req  = HSEL & HTRANS[1] & HREADY;
  assign TRANS_HOLD = hold_q | trans_req;
  assign accept     = TRANS_HOLD & ACTIVE_DEC & HREADY_DEC;
  assign capture    = ~hold_q & trans_req & ~accept;

  always_comb begin
    hold_d       = hold_q;
    data_phase_d = data_phase_q;
    addr_d       = addr_q;
    ctrl_d       = ctrl_q;
    if (capture) begin
      hold_d = 1'b1;
      addr_d = HADDR;
      ctrl_d = ctrl_live;
    end else if (hold_q && accept) begin
      hold_d = 1'b0;
    end
    // A new acceptance overlaps the previous data phase.
    if (accept)
      data_phase_d = 1'b1;
    else if (data_phase_q && HREADYOUT_DEC)
      data_phase_d = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_q       <= 1'b0;
      data_phase_q <= 1'b0;
      addr_q       <= '0;
      ctrl_q       <= '0;
    end else begin
      hold_q       <= hold_d;
      data_phase_q <= data_phase_d;
      addr_q       <= addr_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign ctrl_o   = hold_q ? ctrl_q : ctrl_live;
  assign HADDR_O  = hold_q ? addr_q : HADDR;
  assign HSEL_O   = ctrl_o.hsel;
  assign HTRANS_O = ctrl_o.htrans;
  assign HWRITE_O = ctrl_o.hwrite;
  assign HSIZE_O  = ctrl_o.hsize;
  assign HBURST_O = ctrl_o.hburst;
  assign HPROT_O  = ctrl_o.hprot;

  always_comb begin
    HREADYOUT = 1'b1;
    if (hold_q || (trans_req && !accept))
      HREADYOUT = 1'b0;
    else if (data_phase_q)
      HREADYOUT = HREADYOUT_DEC;
  end

  assign HRESP = data_phase_q ? HRESP_DEC : HRESP_OKAY;

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage.sv
// Directed bench for the bus matrix input stage.
// Inputs change 1ns after the rising edge; outputs checked 1ns later.
module tb_ahblite_busmatrix_inputstage;
  import ahblite_busmatrix_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HREADY;
  logic        ACTIVE_DEC;
  logic        HREADY_DEC;
  logic        HREADYOUT_DEC;
  logic        HRESP_DEC;
  logic        TRANS_HOLD;
  logic        HSEL_O;
  logic [31:0] HADDR_O;
  logic [1:0]  HTRANS_O;
  logic        HWRITE_O;
  logic [2:0]  HSIZE_O;
  logic [2:0]  HBURST_O;
  logic [3:0]  HPROT_O;
  logic        HREADYOUT;
  logic        HRESP;

  int checks = 0;
  int errors = 0;

  ahblite_busmatrix_inputstage #(.ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HREADY(HREADY),
    .ACTIVE_DEC(ACTIVE_DEC), .HREADY_DEC(HREADY_DEC),
    .HREADYOUT_DEC(HREADYOUT_DEC), .HRESP_DEC(HRESP_DEC),
    .TRANS_HOLD(TRANS_HOLD), .HSEL_O(HSEL_O), .HADDR_O(HADDR_O),
    .HTRANS_O(HTRANS_O), .HWRITE_O(HWRITE_O), .HSIZE_O(HSIZE_O),
    .HBURST_O(HBURST_O), .HPROT_O(HPROT_O),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0; HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0;
    HREADY = 1'b1; ACTIVE_DEC = 1'b0; HREADY_DEC = 1'b1;
    HREADYOUT_DEC = 1'b1; HRESP_DEC = 1'b0;
    step(); step();
    HRESET = 1'b0;
    settle();
    chk("rst_hold", 32'(TRANS_HOLD), 0);
    chk("rst_rdy", 32'(HREADYOUT), 1);
    chk("rst_resp", 32'(HRESP), 0);

    // Granted NONSEQ read
    step();
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h2000_0010;
    HSIZE = 3'd2; ACTIVE_DEC = 1'b1;
    settle();
    chk("g_hold", 32'(TRANS_HOLD), 1);
    chk("g_addr", HADDR_O, 32'h2000_0010);
    chk("g_rdy", 32'(HREADYOUT), 1);
    step();
    HTRANS = HTRANS_IDLE; HREADYOUT_DEC = 1'b0;
    settle();
    chk("g_dp_rdy0", 32'(HREADYOUT), 0);
    chk("g_dp_hold", 32'(TRANS_HOLD), 0);
    HREADYOUT_DEC = 1'b1;
    settle();
    chk("g_dp_rdy1", 32'(HREADYOUT), 1);
    step();
    HREADYOUT_DEC = 1'b0;
    settle();
    chk("g_dp_clr", 32'(HREADYOUT), 1);
    HREADYOUT_DEC = 1'b1;

    // Write held for three cycles
    HTRANS = HTRANS_NONSEQ; HADDR = 32'h2000_0040; HWRITE = 1'b1;
    HPROT = 4'd3; ACTIVE_DEC = 1'b0;
    settle();
    chk("h0_rdy", 32'(HREADYOUT), 0);
    chk("h0_hold", 32'(TRANS_HOLD), 1);
    chk("h0_addr", HADDR_O, 32'h2000_0040);
    step();
    HADDR = 32'h2000_0080; HWRITE = 1'b0; HPROT = 4'd0; HREADY = 1'b0;
    settle();
    chk("h1_rdy", 32'(HREADYOUT), 0);
    chk("h1_hold", 32'(TRANS_HOLD), 1);
    chk("h1_addr", HADDR_O, 32'h2000_0040);
    chk("h1_wr", 32'(HWRITE_O), 1);
    chk("h1_prot", 32'(HPROT_O), 3);
    step();
    settle();
    chk("h2_rdy", 32'(HREADYOUT), 0);
    chk("h2_addr", HADDR_O, 32'h2000_0040);
    step();
    ACTIVE_DEC = 1'b1;
    settle();
    chk("h3_rdy", 32'(HREADYOUT), 0);
    chk("h3_addr", HADDR_O, 32'h2000_0040);
    step();
    HTRANS = HTRANS_IDLE; HREADY = 1'b1;
    settle();
    chk("h4_hold", 32'(TRANS_HOLD), 0);
    chk("h4_rdy", 32'(HREADYOUT), 1);
    chk("h4_addr", HADDR_O, 32'h2000_0080);
    step();

    // INCR4 burst, always granted
    HBURST = 3'd3; HSIZE = 3'd2;
    for (int i = 0; i < 4; i++) begin
      HTRANS = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      HADDR = 32'h100 + 32'(4 * i);
      settle();
      chk("b_rdy", 32'(HREADYOUT), 1);
      chk("b_addr", HADDR_O, 32'h100 + 32'(4 * i));
      chk("b_hold", 32'(TRANS_HOLD), 1);
      step();
    end
    HTRANS = HTRANS_IDLE; HREADYOUT_DEC = 1'b0;
    settle();
    chk("b_dp_last", 32'(HREADYOUT), 0);
    HREADYOUT_DEC = 1'b1;
    step();

    // Two-cycle ERROR response
    HTRANS = HTRANS_NONSEQ; HADDR = 32'h200; HBURST = 3'd0;
    step();
    HTRANS = HTRANS_IDLE; HREADYOUT_DEC = 1'b0; HRESP_DEC = 1'b1;
    settle();
    chk("e1_rdy", 32'(HREADYOUT), 0);
    chk("e1_resp", 32'(HRESP), 1);
    step();
    HREADYOUT_DEC = 1'b1;
    settle();
    chk("e2_rdy", 32'(HREADYOUT), 1);
    chk("e2_resp", 32'(HRESP), 1);
    step();
    settle();
    chk("e3_resp", 32'(HRESP), 0);
    chk("e3_rdy", 32'(HREADYOUT), 1);
    HRESP_DEC = 1'b0;

    // Reset while a transfer is held
    ACTIVE_DEC = 1'b0; HTRANS = HTRANS_NONSEQ; HADDR = 32'h300;
    step();
    HTRANS = HTRANS_IDLE; HREADY = 1'b0; HADDR = 32'h400;
    HRESP_DEC = 1'b1;
    settle();
    chk("r_held", 32'(TRANS_HOLD), 1);
    chk("r_held_addr", HADDR_O, 32'h300);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0; HREADY = 1'b1;
    settle();
    chk("r_hold", 32'(TRANS_HOLD), 0);
    chk("r_rdy", 32'(HREADYOUT), 1);
    chk("r_resp", 32'(HRESP), 0);
    chk("r_addr", HADDR_O, 32'h400);
    HRESP_DEC = 1'b0;

    // IDLE with HSEL=1
    HSEL = 1'b1; HTRANS = HTRANS_IDLE; ACTIVE_DEC = 1'b1;
    settle();
    chk("i_hold", 32'(TRANS_HOLD), 0);
    chk("i_rdy", 32'(HREADYOUT), 1);
    step();
    HREADYOUT_DEC = 1'b0;
    settle();
    chk("i_nodp", 32'(HREADYOUT), 1);
    HTRANS = HTRANS_BUSY;
    settle();
    chk("busy_hold", 32'(TRANS_HOLD), 0);
    chk("busy_rdy", 32'(HREADYOUT), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
